// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and operation-decode helpers for the
// iterative RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Divide family occupies the upper half of the func3 space.
  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM (not MULHSU).
  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath, retiring BPC bits per call.
// Multiply: acc = {partial product, remaining multiplier bits}, shift-add, shift right.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}, restoring.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_acc;
  logic [XLEN:0]     w_part;

  // Unrolled BPC single-bit steps on the accumulator.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch so no latch is inferred.
    w_acc  = i_acc;
    w_part = '0;
    for (int k = 0; k < BPC; k++) begin
      if (i_is_div) begin
        // Shift the next dividend bit into the remainder; subtract if it fits.
        w_part = {w_acc[2*XLEN-1:XLEN], w_acc[XLEN-1]};
        w_acc  = {w_acc[2*XLEN-2:0], 1'b0};
        if (w_part >= {1'b0, i_operand}) begin
          w_part   = w_part - {1'b0, i_operand};
          w_acc[0] = 1'b1;
        end
        w_acc[2*XLEN-1:XLEN] = w_part[XLEN-1:0];
      end else begin
        // Add the multiplicand when the current multiplier bit is set, then shift right.
        w_part = {1'b0, w_acc[2*XLEN-1:XLEN]} + (w_acc[0] ? {1'b0, i_operand} : {(XLEN+1){1'b0}});
        w_acc  = {w_part, w_acc[XLEN-1:1]};
      end
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes,
// RISC-V corner-case semantics, back-pressure and flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      func3_i,
  input  logic [6:0]      func7_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            error_o
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state, w_next_state;
  logic [CW-1:0]     r_cnt;
  muldiv_op_e        r_op;
  logic              r_neg_rem;   // remainder takes the sign of rs1
  logic              r_neg_res;   // product / quotient negated when signs differ
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic              r_error;

  muldiv_op_e        w_op;
  logic              w_illegal, w_div_zero, w_overflow, w_special, w_accept, w_last;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [2*XLEN-1:0] w_step_acc, w_prod;
  logic [XLEN-1:0]   w_quot_raw, w_rem_raw, w_final;

  // Request decode and operand magnitudes, evaluated on the incoming request.
  assign w_op       = muldiv_op_e'(func3_i);
  assign w_illegal  = (opcode_i != OPCODE_OP) || (func7_i != FUNC7_MULDIV);
  assign w_div_zero = is_div(w_op) && (data2_i == '0);
  assign w_overflow = is_div(w_op) && is_signed_a(w_op) && (data1_i == MOST_NEG) && (data2_i == '1);
  assign w_special  = w_illegal || w_div_zero || w_overflow;
  assign w_a_neg    = is_signed_a(w_op) && data1_i[XLEN-1];
  assign w_b_neg    = is_signed_b(w_op) && data2_i[XLEN-1];
  assign w_a_mag    = w_a_neg ? -data1_i : data1_i;
  assign w_b_mag    = w_b_neg ? -data2_i : data2_i;
  assign w_accept   = ready_o && valid_i && !flush_i;
  assign w_last     = (r_cnt == CW'(ITERS - 1));

  muldiv_step #(
    .XLEN (XLEN),
    .BPC  (BITS_PER_CYCLE)
  ) u_step (
    .i_is_div  (is_div(r_op)),
    .i_acc     (r_acc),
    .i_operand (r_b),
    .o_acc     (w_step_acc)
  );

  // Sign fix-up and result selection on the output of the final iteration.
  assign w_prod     = r_neg_res ? -w_step_acc : w_step_acc;
  assign w_quot_raw = w_step_acc[XLEN-1:0];
  assign w_rem_raw  = w_step_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = r_neg_res ? -w_quot_raw : w_quot_raw;
      OP_REM, OP_REMU:              w_final = r_neg_rem ? -w_rem_raw : w_rem_raw;
      default:                      w_final = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // FSM next-state and handshake outputs; flush overrides everything.
  always_comb begin
    w_next_state = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) w_next_state = w_special ? DONE : BUSY;
      end
      BUSY: if (w_last) w_next_state = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (flush_i) w_next_state = IDLE;
  end

  // Datapath: load magnitudes on accept, iterate in BUSY, capture the result on the last step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: datapath registers are reset as well so result_o reads 0 straight out of reset.
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_neg_rem <= 1'b0;
      r_neg_res <= 1'b0;
      r_acc     <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_error   <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_op      <= w_op;
      r_neg_rem <= w_a_neg;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_acc     <= {{XLEN{1'b0}}, w_a_mag};
      r_b       <= w_b_mag;
      r_error   <= w_illegal;
      if (w_illegal)       r_result <= '0;
      else if (w_div_zero) r_result <= is_rem(w_op) ? data1_i : '1;
      else if (w_overflow) r_result <= is_rem(w_op) ? '0 : data1_i;
    end else if ((r_state == BUSY) && !flush_i) begin
      r_acc <= w_step_acc;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_result <= w_final;
    end
  end

  assign result_o = r_result;
  assign error_o  = r_error;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: directed table and hand sequences on a 32-bit/1-bit
// instance, random regression on a 64-bit/4-bit instance against a model.
module tb_muldiv_unit;

  localparam logic [6:0]  OPC  = 7'b0110011;
  localparam logic [6:0]  F7   = 7'b0000001;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit, 1 bit per cycle instance
  logic        flush32, valid32_i, ready32_o, valid32_o, rdy32_i, err32;
  logic [6:0]  opc32, f7_32;
  logic [2:0]  f3_32;
  logic [31:0] a32, b32, res32;

  // 64-bit, 4 bits per cycle instance
  logic        flush64, valid64_i, ready64_o, valid64_o, rdy64_i, err64;
  logic [6:0]  opc64, f7_64;
  logic [2:0]  f3_64;
  logic [63:0] a64, b64, res64;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush32), .valid_i(valid32_i), .ready_o(ready32_o),
    .opcode_i(opc32), .func3_i(f3_32), .func7_i(f7_32), .data1_i(a32), .data2_i(b32),
    .valid_o(valid32_o), .ready_i(rdy32_i), .result_o(res32), .error_o(err32)
  );

  muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush64), .valid_i(valid64_i), .ready_o(ready64_o),
    .opcode_i(opc64), .func3_i(f3_64), .func7_i(f7_64), .data1_i(a64), .data2_i(b64),
    .valid_o(valid64_o), .ready_i(rdy64_i), .result_o(res64), .error_o(err64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: RISC-V M semantics from wide plain arithmetic.
  function automatic logic [63:0] ref64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'b0, a};
    ub = {64'b0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[63:0];   end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: begin
        if (b == 64'd0) return '1;
        if (a == MIN64 && b == '1) return MIN64;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 64'd0) ? '1 : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == MIN64 && b == '1) return 64'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return MIN64;
      2:       return '1;
      3:       return 64'($urandom_range(0, 20));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // All drivers below are called at a falling edge.
  task automatic issue32(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
    opc32 = opc; f7_32 = f7; f3_32 = f3; a32 = a; b32 = b; valid32_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid32_i = 1'b0; a32 = $urandom(); b32 = $urandom(); f3_32 = 3'($urandom());
  endtask

  task automatic wait32(output int lat, output bit busy_ok);
    lat = 1; busy_ok = 1'b1;
    while (valid32_o !== 1'b1 && lat < 200) begin
      if (ready32_o !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop32();
    rdy32_i = 1'b1;
    @(negedge clk);
    rdy32_i = 1'b0;
  endtask

  task automatic run64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    opc64 = OPC; f7_64 = F7; f3_64 = f3; a64 = a; b64 = b; valid64_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid64_i = 1'b0; a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
    lat = 1;
    while (valid64_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = res64;
    rdy64_i = 1'b1;
    @(negedge clk);
    rdy64_i = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          lat, seen;
    bit          bok;
    logic [31:0] held;
    logic [63:0] r64, e64, ra, rb;
    logic [2:0]  rf3;
    int          elat;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[5]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[6]  = '{3'b101, 32'd1234,     32'd0,        32'hFFFFFFFF, 1};
    vecs[7]  = '{3'b111, 32'd1234,     32'd0,        32'd1234,     1};
    vecs[8]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[9]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[10] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[11] = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[12] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
    vecs[13] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};

    rst_n = 1'b0;
    flush32 = 0; valid32_i = 0; rdy32_i = 0; opc32 = OPC; f7_32 = F7; f3_32 = 0; a32 = 0; b32 = 0;
    flush64 = 0; valid64_i = 0; rdy64_i = 0; opc64 = OPC; f7_64 = F7; f3_64 = 0; a64 = 0; b64 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ready_o", 64'(ready32_o), 64'd1);
    check("reset valid_o", 64'(valid32_o), 64'd0);
    check("reset result_o", 64'(res32), 64'd0);
    check("reset error_o", 64'(err32), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      issue32(OPC, F7, vecs[i].f3, vecs[i].a, vecs[i].b);
      wait32(lat, bok);
      check($sformatf("vec%0d result", i), 64'(res32), 64'(vecs[i].exp));
      check($sformatf("vec%0d error", i), 64'(err32), 64'd0);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d ready low while busy", i), 64'(bok), 64'd1);
      pop32();
    end

    // Back-pressure: hold ready_i low for 10 cycles
    issue32(OPC, F7, 3'b000, 32'd3, 32'd5);
    wait32(lat, bok);
    held = res32;
    check("bp result", 64'(held), 64'd15);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp result stable", 64'(res32), 64'(held));
      check("bp valid held", 64'(valid32_o), 64'd1);
      check("bp ready low", 64'(ready32_o), 64'd0);
    end
    pop32();
    check("bp ready after pop", 64'(ready32_o), 64'd1);
    check("bp valid after pop", 64'(valid32_o), 64'd0);

    // Illegal requests
    issue32(OPC, 7'b0100000, 3'b000, 32'd5, 32'd6);
    wait32(lat, bok);
    check("illegal f7 latency", 64'(lat), 64'd1);
    check("illegal f7 error", 64'(err32), 64'd1);
    check("illegal f7 result", 64'(res32), 64'd0);
    pop32();
    issue32(7'b0010011, F7, 3'b100, 32'd5, 32'd0);
    wait32(lat, bok);
    check("illegal opc latency", 64'(lat), 64'd1);
    check("illegal opc error", 64'(err32), 64'd1);
    check("illegal opc result", 64'(res32), 64'd0);
    pop32();

    // Flush beats accept in the same cycle
    opc32 = OPC; f7_32 = F7; f3_32 = 3'b000; a32 = 32'd9; b32 = 32'd9;
    valid32_i = 1'b1; flush32 = 1'b1;
    @(negedge clk);
    valid32_i = 1'b0; flush32 = 1'b0;
    check("flush vs accept ready", 64'(ready32_o), 64'd1);
    check("flush vs accept valid", 64'(valid32_o), 64'd0);

    // Flush at BUSY cycle 5: the result never appears
    issue32(OPC, F7, 3'b101, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    check("flush ready back", 64'(ready32_o), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid32_o === 1'b1) seen++;
      @(negedge clk);
    end
    check("flush no valid", 64'(seen), 64'd0);
    issue32(OPC, F7, 3'b000, 32'd6, 32'd7);
    wait32(lat, bok);
    check("post-flush result", 64'(res32), 64'd42);
    check("post-flush latency", 64'(lat), 64'd33);
    pop32();

    // Reset at BUSY cycle 10: outputs return to reset values before the next edge
    issue32(OPC, F7, 3'b011, 32'hFFFFFFFF, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset ready_o", 64'(ready32_o), 64'd1);
    check("mid reset valid_o", 64'(valid32_o), 64'd0);
    check("mid reset result_o", 64'(res32), 64'd0);
    check("mid reset error_o", 64'(err32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid32_o === 1'b1) seen++;
    end
    check("post reset no valid", 64'(seen), 64'd0);
    issue32(OPC, F7, 3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE);
    wait32(lat, bok);
    check("post-reset REM", 64'(res32), 64'hFFFFFFFF);
    pop32();

    // Random regression on the 64-bit / 4-bits-per-cycle instance
    for (int n = 0; n < 1000; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick64();
      rb  = pick64();
      e64 = ref64(rf3, ra, rb);
      elat = (rf3[2] && (rb == 64'd0 || (!rf3[0] && ra == MIN64 && rb == '1))) ? 1 : 17;
      run64(rf3, ra, rb, r64, lat);
      check($sformatf("rand%0d op%0d %h %h result", n, rf3, ra, rb), r64, e64);
      check($sformatf("rand%0d op%0d latency", n, rf3), 64'(lat), 64'(elat));
    end
    check("rand error_o", 64'(err64), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
